instr_encode_loader: RTL and testbench

- Write-side counterpart of the single-cycle processor's instruction decoder.
- Accepts decoded instruction descriptors (class, func, register indices, imm) over a valid/ready stream.
- Packs each descriptor into the processor's 32-bit instruction word.
- Writes the words sequentially into instruction memory while holding the processor, then releases it.

---
 rtl/instr_encode_loader_pkg.sv | 47 ++++
 rtl/instr_word_pack.sv | 51 +++++
 rtl/instr_encode_loader.sv | 118 +++++++++++
 tb/tb_instr_encode_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encode_loader_pkg.sv
// ============================================================================
// instr_encode_loader_pkg : opcodes, field positions, class and FSM encodings
// Revision: 1.0
// ============================================================================
`default_nettype none

package instr_encode_loader_pkg;

   typedef enum logic [2:0] {
      CLS_ALU_R  = 3'd0,
      CLS_ALU_I  = 3'd1,
      CLS_CMP_R  = 3'd2,
      CLS_CMP_I  = 3'd3,
      CLS_LOAD   = 3'd4,
      CLS_STORE  = 3'd5,
      CLS_BRANCH = 3'd6,
      CLS_JAL    = 3'd7
   } instr_class_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } load_state_e;

   localparam logic [3:0] OP_ALUR   = 4'b0000;
   localparam logic [3:0] OP_ALUI   = 4'b1000;
   localparam logic [3:0] OP_CMPR   = 4'b0010;
   localparam logic [3:0] OP_CMPI   = 4'b1010;
   localparam logic [3:0] OP_LOAD   = 4'b1001;
   localparam logic [3:0] OP_STORE  = 4'b0101;
   localparam logic [3:0] OP_BRANCH = 4'b0110;
   localparam logic [3:0] OP_JAL    = 4'b1011;

   // Register slots A/B/C hold rd/rs1/rs2, or rs1/rs2 for STORE and BRANCH.
   localparam int F_RA_LSB   = 28;
   localparam int F_RB_LSB   = 24;
   localparam int F_RC_LSB   = 20;
   localparam int F_IMM_LSB  = 8;
   localparam int F_FUNC_LSB = 4;
   localparam int F_OP_LSB   = 0;

endpackage

`default_nettype wire

// File: rtl/instr_word_pack.sv
// ============================================================================
// instr_word_pack : combinational descriptor-to-instruction-word packer
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_word_pack
   import instr_encode_loader_pkg::*;
(
   input  logic [2:0]  class_i,
   input  logic [3:0]  func_i,
   input  logic [3:0]  rd_i,
   input  logic [3:0]  rs1_i,
   input  logic [3:0]  rs2_i,
   input  logic [15:0] imm_i,
   output logic [31:0] word_o
);

   always_comb begin
      word_o = '0;
      word_o[F_FUNC_LSB +: 4] = func_i;
      case (class_i)
         CLS_ALU_R, CLS_CMP_R: begin
            word_o[F_OP_LSB +: 4] = (class_i == CLS_ALU_R) ? OP_ALUR : OP_CMPR;
            word_o[F_RA_LSB +: 4] = rd_i;
            word_o[F_RB_LSB +: 4] = rs1_i;
            word_o[F_RC_LSB +: 4] = rs2_i;
         end
         CLS_STORE, CLS_BRANCH: begin
            word_o[F_OP_LSB +: 4]   = (class_i == CLS_STORE) ? OP_STORE : OP_BRANCH;
            word_o[F_RA_LSB +: 4]   = rs1_i;
            word_o[F_RB_LSB +: 4]   = rs2_i;
            word_o[F_IMM_LSB +: 16] = imm_i;
         end
         default: begin
            case (class_i)
               CLS_ALU_I: word_o[F_OP_LSB +: 4] = OP_ALUI;
               CLS_CMP_I: word_o[F_OP_LSB +: 4] = OP_CMPI;
               CLS_LOAD:  word_o[F_OP_LSB +: 4] = OP_LOAD;
               default:   word_o[F_OP_LSB +: 4] = OP_JAL;
            endcase
            word_o[F_RA_LSB +: 4]   = rd_i;
            word_o[F_RB_LSB +: 4]   = rs1_i;
            word_o[F_IMM_LSB +: 16] = imm_i;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/instr_encode_loader.sv
// ============================================================================
// instr_encode_loader : streams descriptors, packs them and writes imem
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_encode_loader
   import instr_encode_loader_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_class,
   input  logic [3:0]        in_func,
   input  logic [3:0]        in_rd,
   input  logic [3:0]        in_rs1,
   input  logic [3:0]        in_rs2,
   input  logic [15:0]       in_imm,
   input  logic              in_last,
   output logic              imem_wr_en,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wr_data,
   output logic              cpu_hold,
   output logic [ADDR_W:0]   word_count,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);

   load_state_e       state_q, state_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       w_word;
   logic              w_full;

   instr_word_pack u_pack (
      .class_i (in_class),
      .func_i  (in_func),
      .rd_i    (in_rd),
      .rs1_i   (in_rs1),
      .rs2_i   (in_rs2),
      .imm_i   (in_imm),
      .word_o  (w_word)
   );

   // The count equals the pointer offset from BASE_ADDR, so it doubles as the overflow test.
   assign w_full = (count_q >= C_DEPTH);

   always_comb begin
      state_d = state_q;
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d = ST_LOAD;
               count_d = '0;
               addr_d  = C_BASE;
            end
         end
         ST_LOAD: begin
            if (in_valid) begin
               if (w_full) begin
                  state_d = ST_ERROR;
               end else begin
                  wr_en_d = 1'b1;
                  addr_d  = C_BASE + count_q[ADDR_W-1:0];
                  data_d  = w_word;
                  count_d = count_q + 1'b1;
                  if (in_last) state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         wr_en_q <= 1'b0;
         addr_q  <= C_BASE;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   assign in_ready     = (state_q == ST_LOAD);
   assign cpu_hold     = (state_q == ST_LOAD) || (state_q == ST_FLUSH) || (state_q == ST_ERROR);
   assign done         = (state_q == ST_DONE);
   assign err          = (state_q == ST_ERROR);
   assign imem_wr_en   = wr_en_q;
   assign imem_addr    = addr_q;
   assign imem_wr_data = data_q;
   assign word_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encode_loader.sv
// ============================================================================
// tb_instr_encode_loader : scoreboard bench for instr_encode_loader (DEPTH=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_encode_loader;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_class = '0;
   logic [3:0]  in_func = '0;
   logic [3:0]  in_rd = '0;
   logic [3:0]  in_rs1 = '0;
   logic [3:0]  in_rs2 = '0;
   logic [15:0] in_imm = '0;
   logic        in_last = 1'b0;
   logic        imem_wr_en;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wr_data;
   logic        cpu_hold;
   logic [10:0] word_count;
   logic        done;
   logic        err;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic [9:0] exp_addr = '0;
   exp_t exp_q[$];
   int   wr_cyc[$];

   instr_encode_loader #(
      .ADDR_W    (10),
      .BASE_ADDR (0),
      .DEPTH     (4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_class     (in_class),
      .in_func      (in_func),
      .in_rd        (in_rd),
      .in_rs1       (in_rs1),
      .in_rs2       (in_rs2),
      .in_imm       (in_imm),
      .in_last      (in_last),
      .imem_wr_en   (imem_wr_en),
      .imem_addr    (imem_addr),
      .imem_wr_data (imem_wr_data),
      .cpu_hold     (cpu_hold),
      .word_count   (word_count),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every write strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (imem_wr_en === 1'b1) begin
         total++;
         wr_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%0h data=%08h, required no write", imem_addr, imem_wr_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (imem_addr !== e.addr || imem_wr_data !== e.data) begin
               bad++;
               $display("FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                        imem_addr, imem_wr_data, e.addr, e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic chk_status(input string name, input logic rdy, input logic hold,
                             input logic dn, input logic er, input logic [10:0] wc);
      chk({name, ".in_ready"}, 64'(in_ready), 64'(rdy));
      chk({name, ".cpu_hold"}, 64'(cpu_hold), 64'(hold));
      chk({name, ".done"}, 64'(done), 64'(dn));
      chk({name, ".err"}, 64'(err), 64'(er));
      chk({name, ".word_count"}, 64'(word_count), 64'(wc));
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called just after a posedge; leaves just after the posedge that saw start.
   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      exp_addr = '0;
   endtask

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic send(input logic [2:0] cls, input logic [3:0] func, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2, input logic [15:0] imm,
                       input logic last, input logic exp_wr, input logic [31:0] exp_data);
      bit ok = 0;
      in_class = cls; in_func = func; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_imm = imm; in_last = last; in_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            if (exp_wr) begin
               exp_q.push_back('{addr: exp_addr, data: exp_data});
               exp_addr = exp_addr + 1'b1;
            end
            @(posedge clk);
            ok = 1;
            break;
         end
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL handshake_timeout: got in_ready=%b, required 1 within 20 cycles", in_ready);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #1 reset_n = 1'b0;
      #2;
      chk("rst.wr_en", 64'(imem_wr_en), 64'(0));
      chk("rst.addr", 64'(imem_addr), 64'(0));
      chk("rst.data", 64'(imem_wr_data), 64'(0));
      chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
      tick(2);
      reset_n = 1'b1;
      tick(1);

      // Single ALU_R with last
      pulse_start();
      chk_status("t1_load", 1'b1, 1'b1, 1'b0, 1'b0, 11'd0);
      send(3'd0, 4'd0, 4'd3, 4'd1, 4'd2, 16'h0000, 1'b1, 1'b1, 32'h31200000);
      chk("t1.flush_hold", 64'(cpu_hold), 64'(1));
      tick(1);
      chk_status("t1_done", 1'b0, 1'b0, 1'b1, 1'b0, 11'd1);

      // Back-to-back ALU_I, BRANCH, JAL
      pulse_start();
      chk_status("t2_load", 1'b1, 1'b1, 1'b0, 1'b0, 11'd0);
      wr_cyc.delete();
      send(3'd1, 4'd0, 4'd5,  4'd0, 4'd0, 16'h0010, 1'b0, 1'b1, 32'h50001008);
      send(3'd6, 4'd2, 4'd0,  4'd4, 4'd6, 16'hFFFE, 1'b0, 1'b1, 32'h46FFFE26);
      send(3'd7, 4'd0, 4'd15, 4'd2, 4'd0, 16'h0004, 1'b1, 1'b1, 32'hF200040B);
      tick(1);
      chk_status("t2_done", 1'b0, 1'b0, 1'b1, 1'b0, 11'd3);
      chk("t2.writes", 64'(wr_cyc.size()), 64'(3));
      if (wr_cyc.size() == 3) begin
         chk("t2.gap01", 64'(wr_cyc[1] - wr_cyc[0]), 64'(1));
         chk("t2.gap12", 64'(wr_cyc[2] - wr_cyc[1]), 64'(1));
      end

      // in_valid toggling; fills to the last legal address
      pulse_start();
      send(3'd2, 4'd5, 4'd1, 4'd2,  4'd3,  16'h0000, 1'b0, 1'b1, 32'h12300052);
      tick(1);
      send(3'd3, 4'd3, 4'd7, 4'd8,  4'd0,  16'h1234, 1'b0, 1'b1, 32'h7812343A);
      tick(2);
      chk("t3.gap_count", 64'(word_count), 64'(2));
      send(3'd4, 4'd0, 4'd9, 4'd10, 4'd0,  16'hABCD, 1'b0, 1'b1, 32'h9AABCD09);
      tick(1);
      send(3'd5, 4'd0, 4'd3, 4'd11, 4'd12, 16'h0F0F, 1'b1, 1'b1, 32'hBC0F0F05);
      tick(1);
      chk_status("t3_done", 1'b0, 1'b0, 1'b1, 1'b0, 11'd4);

      // Reset during write cycle of second word
      pulse_start();
      send(3'd0, 4'd0, 4'd1, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1, 32'h10000000);
      send(3'd0, 4'd0, 4'd2, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 32'h0);
      reset_n = 1'b0;
      #1;
      chk("t4.wr_en", 64'(imem_wr_en), 64'(0));
      chk("t4.addr", 64'(imem_addr), 64'(0));
      chk("t4.data", 64'(imem_wr_data), 64'(0));
      chk_status("t4_rst", 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
      tick(3);
      reset_n = 1'b1;
      tick(3);
      chk_status("t4_idle", 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);

      // start during LOAD is ignored
      pulse_start();
      send(3'd0, 4'd9, 4'd2, 4'd3, 4'd4, 16'hFFFF, 1'b0, 1'b1, 32'h23400090);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk_status("t5_load", 1'b1, 1'b1, 1'b0, 1'b0, 11'd1);
      chk("t5.addr", 64'(imem_addr), 64'(0));
      send(3'd4, 4'd0, 4'd9, 4'd10, 4'd0, 16'hABCD, 1'b1, 1'b1, 32'h9AABCD09);
      tick(1);
      chk_status("t5_done", 1'b0, 1'b0, 1'b1, 1'b0, 11'd2);

      // Overflow: five descriptors into DEPTH=4
      pulse_start();
      for (int k = 0; k < 5; k++)
         send(3'd1, 4'd1, 4'd1, 4'd1, 4'd0, 16'(k), 1'b0, (k < 4), 32'h11000018 | (32'(k) << 8));
      chk_status("t6_err", 1'b0, 1'b1, 1'b0, 1'b1, 11'd4);
      chk("t6.wr_en", 64'(imem_wr_en), 64'(0));
      tick(2);
      chk_status("t6_hold", 1'b0, 1'b1, 1'b0, 1'b1, 11'd4);
      pulse_start();
      chk_status("t6_recover", 1'b1, 1'b1, 1'b0, 1'b0, 11'd0);
      send(3'd0, 4'd0, 4'd3, 4'd1, 4'd2, 16'h0000, 1'b1, 1'b1, 32'h31200000);
      tick(1);
      chk_status("t6_done", 1'b0, 1'b0, 1'b1, 1'b0, 11'd1);

      tick(3);
      chk("sb.pending", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
